// File: rtl/viterbi_final_select.sv
// rtl/viterbi_final_select.sv - K=3 Viterbi terminal path selection with sequential min scan
module viterbi_final_select #(
  parameter int MW  = 8,
  parameter int SW  = 6,
  parameter int ONE = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          term,
  input  logic [MW-1:0] r7,
  input  logic [MW-1:0] r8,
  input  logic [MW-1:0] end_00,
  input  logic [MW-1:0] end_11,
  input  logic [MW-1:0] end_10,
  input  logic [MW-1:0] end_01,
  input  logic [SW-1:0] surv_00,
  input  logic [SW-1:0] surv_11,
  input  logic [SW-1:0] surv_10,
  input  logic [SW-1:0] surv_01,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW+1:0] codeword,
  output logic [MW-1:0] shortest_path,
  output logic          sat
);

  localparam int IW = MW + 3;
  localparam logic [IW-1:0] MAX_MAG = IW'((1 << (MW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, CALC, SCAN, OUT} state_t;

  // Negative zero maps to 0 because the magnitude is negated as a whole.
  function automatic logic signed [IW-1:0] sm2tc(input logic [MW-1:0] x);
    logic signed [IW-1:0] mag;
    mag = $signed({{(IW - MW + 1){1'b0}}, x[MW-2:0]});
    return x[MW-1] ? -mag : mag;
  endfunction

  state_t                   state_q, state_d;
  logic                     term_q, term_d;
  logic [MW-1:0]            r7_q, r7_d, r8_q, r8_d;
  logic [3:0][MW-1:0]       end_q, end_d;
  logic [3:0][SW-1:0]       surv_q, surv_d;
  logic [3:0][IW-1:0]       p_q, p_d;
  logic signed [IW-1:0]     min_q, min_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               k_q, k_d;
  logic                     out_valid_q, out_valid_d;
  logic [SW+1:0]            codeword_q, codeword_d;
  logic [MW-1:0]            sp_q, sp_d;
  logic                     sat_q, sat_d;

  logic signed [IW-1:0]     m7, m8, e11, cand;
  logic [1:0]               cand_idx;
  logic                     min_neg;
  logic [IW-1:0]            min_abs;
  logic [1:0]               suffix;

  assign m7       = -(sm2tc(r7_q) <<< 1);
  assign m8       = -(sm2tc(r8_q) <<< 1);
  assign e11      = m7 + m8 + IW'(ONE);
  assign cand_idx = k_q + 2'd1;
  assign cand     = $signed(p_q[cand_idx]);
  assign min_neg  = min_q[IW-1];
  assign min_abs  = min_neg ? IW'(-min_q) : IW'(min_q);

  always_comb begin
    case (idx_q)
      2'd0:    suffix = 2'b00;
      2'd1:    suffix = 2'b11;
      2'd2:    suffix = 2'b10;
      default: suffix = 2'b01;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    r7_d        = r7_q;
    r8_d        = r8_q;
    end_d       = end_q;
    surv_d      = surv_q;
    p_d         = p_q;
    min_d       = min_q;
    idx_d       = idx_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    codeword_d  = codeword_q;
    sp_d        = sp_q;
    sat_d       = sat_q;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          term_d  = term;
          r7_d    = r7;
          r8_d    = r8;
          end_d   = {end_01, end_10, end_11, end_00};
          surv_d  = {surv_01, surv_10, surv_11, surv_00};
          state_d = CALC;
        end
      end
      CALC: begin
        p_d[0]  = sm2tc(end_q[0]);
        p_d[1]  = sm2tc(end_q[1]) + e11;
        p_d[2]  = sm2tc(end_q[2]) + m7;
        p_d[3]  = sm2tc(end_q[3]) + m8;
        min_d   = sm2tc(end_q[0]);
        idx_d   = 2'd0;
        k_d     = 2'd0;
        state_d = term_q ? OUT : SCAN;
      end
      SCAN: begin
        // Strict less-than keeps the lower index on ties.
        if (cand < min_q) begin
          min_d = cand;
          idx_d = cand_idx;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd2) state_d = OUT;
      end
      default: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          codeword_d  = {surv_q[idx_q], suffix};
          if (min_abs > MAX_MAG) begin
            sat_d = 1'b1;
            sp_d  = {min_neg, {(MW-1){1'b1}}};
          end else begin
            sat_d = 1'b0;
            sp_d  = {min_neg, min_abs[MW-2:0]};
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      term_q      <= 1'b0;
      r7_q        <= '0;
      r8_q        <= '0;
      end_q       <= '0;
      surv_q      <= '0;
      p_q         <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      codeword_q  <= '0;
      sp_q        <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      r7_q        <= r7_d;
      r8_q        <= r8_d;
      end_q       <= end_d;
      surv_q      <= surv_d;
      p_q         <= p_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      codeword_q  <= codeword_d;
      sp_q        <= sp_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign codeword      = codeword_q;
  assign shortest_path = sp_q;
  assign sat           = sat_q;

endmodule
